moore_seq_detector: RTL

- Parametrised Moore-type serial bit-pattern detector; the successor to the fixed 4-bit "1010" detector.
- Adds: programmable pattern and length, an overlap/non-overlap mode, an input-valid qualifier, a synchronous clear and a saturating match counter.
- Sits on a serial bit stream inside the datapath. Its output flags the control logic when the pattern is found.

---
 rtl/seq_det_pkg.sv | 45 ++++
 rtl/sat_counter.sv | 22 ++
 rtl/moore_seq_detector.sv | 71 +++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared elaboration-time helpers for serial pattern detectors
package seq_det_pkg;

  function automatic int state_w(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

  // Longest prefix of the pattern that is a suffix of (first k pattern bits, then b).
  // Stream position p carries pattern bit pat_len-1-p.
  function automatic int next_state(input logic [15:0] pattern, input int pat_len,
                                    input int k, input logic b);
    int   best;
    int   pos;
    logic ok;
    logic s;
    best = 0;
    for (int len = 1; len <= pat_len; len++) begin
      if (len <= k + 1) begin
        ok = 1'b1;
        for (int j = 0; j < len; j++) begin
          pos = k + 1 - len + j;
          s = (pos == k) ? b : pattern[pat_len - 1 - pos];
          if (s != pattern[pat_len - 1 - j]) ok = 1'b0;
        end
        if (ok) best = len;
      end
    end
    return best;
  endfunction

  function automatic int border_len(input logic [15:0] pattern, input int pat_len);
    int   best;
    logic ok;
    best = 0;
    for (int f = 1; f < pat_len; f++) begin
      ok = 1'b1;
      for (int j = 0; j < f; j++) begin
        if (pattern[pat_len - 1 - j] != pattern[f - 1 - j]) ok = 1'b0;
      end
      if (ok) best = f;
    end
    return best;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/moore_seq_detector.sv
// rtl/moore_seq_detector.sv - parametrised Moore serial pattern detector with match counter
module moore_seq_detector
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          in_valid,
  input  logic                          in,
  output logic                          out,
  output logic [CNT_W-1:0]              match_count,
  output logic [$clog2(PAT_LEN+1)-1:0]  state_o
);

  localparam int SW = state_w(PAT_LEN);
  localparam int F  = border_len(16'(PATTERN), PAT_LEN);
  localparam int RESTART = OVERLAP ? F : 0;
  localparam logic [SW-1:0] LAST = SW'(PAT_LEN);

  logic [SW-1:0] trans0 [PAT_LEN+1];
  logic [SW-1:0] trans1 [PAT_LEN+1];
  logic [SW-1:0] state;
  logic [SW-1:0] nxt;
  logic          inc;

  // Transition table; the match state reuses the row of its restart state.
  for (genvar k = 0; k < PAT_LEN; k++) begin : g_row
    assign trans0[k] = SW'(next_state(16'(PATTERN), PAT_LEN, k, 1'b0));
    assign trans1[k] = SW'(next_state(16'(PATTERN), PAT_LEN, k, 1'b1));
  end
  assign trans0[PAT_LEN] = SW'(next_state(16'(PATTERN), PAT_LEN, RESTART, 1'b0));
  assign trans1[PAT_LEN] = SW'(next_state(16'(PATTERN), PAT_LEN, RESTART, 1'b1));

  always_comb begin
    nxt = '0;
    if (state <= LAST) begin
      nxt = in ? trans1[state] : trans0[state];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '0;
    end else if (clear || (state > LAST)) begin
      state <= '0;
    end else if (in_valid) begin
      state <= nxt;
    end
  end

  assign inc = in_valid && !clear && (state <= LAST) && (nxt == LAST);

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (inc),
    .clr  (clear),
    .count(match_count)
  );

  assign out     = (state == LAST);
  assign state_o = state;

endmodule
